// File: rtl/lcd_text_writer.sv
// Streams a 2x16 character frame to an HD44780-style LCD once the init sequencer is done,
// re-sending the whole frame whenever the host has written into the 32-entry character buffer.
module lcd_text_writer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 4,
  parameter int HOLD_CYCLES   = 148
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       RS_lcd,
  output logic       RW_lcd,
  output logic       E_lcd,
  output logic [7:0] data_lcd,
  output logic       busy,
  output logic       frame_done
);

  localparam int MAX_CYCLES =
    (SETUP_CYCLES > E_HIGH_CYCLES)
      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
      : ((E_HIGH_CYCLES > HOLD_CYCLES) ? E_HIGH_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [5:0] LAST_INDEX = 6'd33;
  localparam logic [7:0] CMD_LINE1  = 8'h80;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    PULSE,
    HOLD,
    NEXT,
    DONE
  } state_t;

  state_t           state_reg;
  logic [7:0]       char_buf_reg [32];
  logic [31:0]      entry_we;
  logic             dirty_reg;
  logic [5:0]       index_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rs_reg;
  logic             e_reg;
  logic [7:0]       data_reg;
  logic             busy_reg;
  logic             frame_done_reg;

  logic [5:0]       fetch_index;
  logic             fetch_rs;
  logic [7:0]       fetch_data;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_entry_we
      assign entry_we[gi] = wr_en && (wr_addr == 5'(gi));
    end
  endgenerate

  // Host writes are accepted in every state, including mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        char_buf_reg[i] <= SPACE_CHAR;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (entry_we[i]) begin
          char_buf_reg[i] <= wr_data;
        end
      end
    end
  end

  // Byte about to be latched on SETUP entry: index 0 from CHECK, index+1 from NEXT.
  always_comb begin
    fetch_index = (state_reg == NEXT) ? (index_reg + 6'd1) : 6'd0;
    fetch_rs    = 1'b1;
    fetch_data  = SPACE_CHAR;
    if (fetch_index == 6'd0) begin
      fetch_rs   = 1'b0;
      fetch_data = CMD_LINE1;
    end else if (fetch_index <= 6'd16) begin
      fetch_data = char_buf_reg[5'(fetch_index - 6'd1)];
    end else if (fetch_index == 6'd17) begin
      fetch_rs   = 1'b0;
      fetch_data = CMD_LINE2;
    end else begin
      fetch_data = char_buf_reg[5'(fetch_index - 6'd2)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      dirty_reg      <= 1'b1;
      index_reg      <= '0;
      cnt_reg        <= '0;
      rs_reg         <= 1'b0;
      e_reg          <= 1'b0;
      data_reg       <= 8'h00;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (wr_en) begin
        dirty_reg <= 1'b1;
      end
      unique case (state_reg)
        IDLE: begin
          e_reg    <= 1'b0;
          busy_reg <= 1'b0;
          if (init_done) begin
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (dirty_reg) begin
            // A write landing in this same cycle keeps dirty set for one more frame.
            dirty_reg <= wr_en;
            index_reg <= '0;
            busy_reg  <= 1'b1;
            rs_reg    <= fetch_rs;
            data_reg  <= fetch_data;
            cnt_reg   <= SETUP_LOAD;
            state_reg <= SETUP;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_reg == '0) begin
            e_reg     <= 1'b1;
            cnt_reg   <= E_LOAD;
            state_reg <= PULSE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        PULSE: begin
          if (cnt_reg == '0) begin
            e_reg     <= 1'b0;
            cnt_reg   <= HOLD_LOAD;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= NEXT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        NEXT: begin
          if (index_reg == LAST_INDEX) begin
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            index_reg <= index_reg + 6'd1;
            rs_reg    <= fetch_rs;
            data_reg  <= fetch_data;
            cnt_reg   <= SETUP_LOAD;
            state_reg <= SETUP;
          end
        end
        DONE: begin
          state_reg <= CHECK;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign RS_lcd     = rs_reg;
  assign RW_lcd     = 1'b0;
  assign E_lcd      = e_reg;
  assign data_lcd   = data_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: stimulus pushes expected LCD bytes, a monitor pops them
// on every E rise and also checks strobe timing and frame timing.
module tb_lcd_text_writer;

  localparam int SETUP_C = 2;
  localparam int EHIGH_C = 4;
  localparam int HOLD_C  = 148;
  localparam int BYTE_T  = SETUP_C + EHIGH_C + HOLD_C + 1;
  localparam int FRAME_T = 34 * BYTE_T;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       RS_lcd, RW_lcd, E_lcd, busy, frame_done;
  logic [7:0] data_lcd;

  lcd_text_writer #(
    .SETUP_CYCLES (SETUP_C),
    .E_HIGH_CYCLES(EHIGH_C),
    .HOLD_CYCLES  (HOLD_C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .RS_lcd    (RS_lcd),
    .RW_lcd    (RW_lcd),
    .E_lcd     (E_lcd),
    .data_lcd  (data_lcd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rises = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mb[32];

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input longint act, input longint min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, min, cyc);
    end
  endtask

  // Reference frame: line-1 address command, 16 chars, line-2 address command, 16 chars.
  task automatic push_frame();
    logic [8:0] b;
    b = {1'b0, 8'h80};
    exp_q.push_back(b);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mb[i]});
    b = {1'b0, 8'hC0};
    exp_q.push_back(b);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mb[i]});
  endtask

  // Monitor: timing and byte content checks on the LCD pins.
  initial begin
    logic [8:0] bus, prev_bus, exp_b;
    logic       prev_e, prev_busy;
    int         stable_cnt, high_cnt, hold_cnt, last_rise, frame_start;
    bit         in_hold;
    prev_bus = '0; prev_e = 1'b0; prev_busy = 1'b0; exp_b = '0;
    stable_cnt = 0; high_cnt = 0; hold_cnt = 0; last_rise = 0; frame_start = 0; in_hold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_bus = '0; prev_e = 1'b0; prev_busy = 1'b0;
        stable_cnt = 0; in_hold = 0; rises = 0;
      end else begin
        bus = {RS_lcd, data_lcd};
        if (busy && !prev_busy) begin
          frame_start = cyc;
          rises = 0;
        end
        if (bus != prev_bus) begin
          if (in_hold) chk_ge("hold_after_fall", hold_cnt, HOLD_C);
          in_hold = 0;
          stable_cnt = 1;
        end else begin
          stable_cnt++;
        end
        if (E_lcd && !prev_e) begin
          chk_ge("setup_before_rise", stable_cnt - 1, SETUP_C);
          chk_eq("rw_low", RW_lcd, 0);
          chk_eq("busy_during_byte", busy, 1);
          if (rises > 0) chk_eq("byte_period", cyc - last_rise, BYTE_T);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, expected no E pulse (cycle %0d)", bus, cyc);
          end else begin
            exp_b = exp_q.pop_front();
            chk_eq($sformatf("byte%0d", rises), bus, exp_b);
          end
          last_rise = cyc;
          rises++;
          high_cnt = 1;
          in_hold = 0;
        end else if (E_lcd) begin
          high_cnt++;
        end else if (prev_e) begin
          chk_eq("e_high_width", high_cnt, EHIGH_C);
          in_hold = 1;
          hold_cnt = 1;
        end else if (in_hold) begin
          hold_cnt++;
        end
        if (frame_done) begin
          chk_eq("frame_time", cyc - frame_start, FRAME_T);
          chk_eq("bytes_per_frame", rises, 34);
          chk_eq("busy_low_at_done", busy, 0);
          done_cnt++;
          $display("frame %0d done at cycle %0d, %0d bytes, %0d still queued",
                   done_cnt, cyc, rises, exp_q.size());
        end
        prev_bus = bus;
        prev_e = E_lcd;
        prev_busy = busy;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt < start + n && k < budget) begin
      tick(1);
      k++;
    end
    chk_eq(name, done_cnt - start, n);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k;
    k = 0;
    while (!busy && k < budget) begin
      tick(1);
      k++;
    end
    @(negedge clk);
    #1;
    while (rises < n && k < budget) begin
      tick(1);
      k++;
    end
    chk_ge("reached_byte", rises, n);
  endtask

  task automatic idle_check(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (busy || E_lcd) bad++;
      tick(1);
    end
    chk_eq(name, bad, 0);
    chk_eq({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic spaces_model();
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_E"}, E_lcd, 0);
    chk_eq({tag, "_RS_RW"}, {RS_lcd, RW_lcd}, 0);
    chk_eq({tag, "_data"}, data_lcd, 0);
    chk_eq({tag, "_busy_done"}, {busy, frame_done}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    init_done = 1'b0;
    exp_q.delete();
    spaces_model();
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] a, a2;
    logic [7:0] d, d2;
    logic [4:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] hello[5];
    int n_extra;
    int bad;

    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    // Power-up frame of spaces once init_done rises at cycle 10.
    do_reset();
    while (cyc < 10) tick(1);
    push_frame();
    init_done = 1'b1;
    wait_done(1, FRAME_T + 100, "t1_frames");
    idle_check(200, "t1_idle");

    // HELLO plus a few random characters written back to back while idle: two frames.
    for (int i = 0; i < 5; i++) begin
      wa.push_back(5'(i));
      wd.push_back(hello[i]);
    end
    n_extra = int'($urandom_range(1, 3));
    for (int i = 0; i < n_extra; i++) begin
      wa.push_back(5'($urandom_range(5, 31)));
      wd.push_back(8'($urandom_range(33, 126)));
    end
    foreach (wa[i]) mb[wa[i]] = wd[i];
    push_frame();
    push_frame();
    foreach (wa[i]) do_write(wa[i], wd[i]);
    wait_done(2, 2 * FRAME_T + 200, "t2_frames");
    idle_check(200, "t2_idle");

    // Writes during byte 5 of a frame: frame completes, exactly one extra frame follows.
    a  = 5'($urandom_range(0, 4));
    d  = 8'($urandom_range(33, 126));
    a2 = 5'($urandom_range(6, 29));
    d2 = 8'($urandom_range(33, 126));
    mb[a] = d;
    mb[31] = 8'h41;
    mb[a2] = d2;
    push_frame();
    push_frame();
    do_write(a, d);
    wait_rises(6, 2 * FRAME_T);
    do_write(5'd31, 8'h41);
    tick(10);
    do_write(a2, d2);
    wait_done(2, 2 * FRAME_T + 200, "t4_frames");
    idle_check(300, "t4_idle");

    // init_done held low with writes: nothing moves until it rises.
    do_reset();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy || E_lcd) bad++;
      if (i % 100 == 50) begin
        a = 5'($urandom_range(0, 31));
        d = 8'($urandom_range(33, 126));
        mb[a] = d;
        do_write(a, d);
      end else begin
        tick(1);
      end
    end
    chk_eq("t5_quiet_before_init", bad, 0);
    push_frame();
    init_done = 1'b1;
    wait_done(1, FRAME_T + 100, "t5_frames");
    idle_check(200, "t5_idle");

    // Reset during the E pulse of byte 20.
    a = 5'($urandom_range(0, 31));
    d = 8'($urandom_range(33, 126));
    mb[a] = d;
    push_frame();
    do_write(a, d);
    wait_rises(21, 2 * FRAME_T);
    chk_eq("t6_e_high_before_reset", E_lcd, 1);
    reset = 1'b1;
    init_done = 1'b0;
    exp_q.delete();
    spaces_model();
    tick(1);
    check_reset_outputs("t6_midframe_reset");
    tick(2);
    reset = 1'b0;
    idle_check(300, "t6_wait_init");
    push_frame();
    init_done = 1'b1;
    wait_done(1, FRAME_T + 100, "t6_frames");
    idle_check(200, "t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
